// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned ADDR_W     = 8;
    localparam int unsigned INSTR_W    = 32;
    localparam logic [7:0]  RESET_PC   = 8'h00;
    localparam int unsigned PC_STEP    = 4;
    localparam int unsigned R15_OFFSET = 8;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry skid queue between the fetch PC and decode.
// Push is accepted when a slot is free or the head leaves in the same cycle;
// flush empties the queue and wins over push.
module fetch_skid_fifo
    import fetch_pkg::*;
#(
    parameter type entry_t = fetch_entry_t
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  entry_t     push_data_i,
    input  logic       pop_i,
    input  logic       flush_i,
    output logic [1:0] count_o,
    output logic       head_valid_o,
    output entry_t     head_o
);

    entry_t     mem_q [2];
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic       wr_ptr;
    logic       pop_eff;
    logic       push_eff;

    // Queue bookkeeping: effective push/pop, write slot, next pointer and count
    always_comb begin
        pop_eff  = pop_i & (count_q != 2'd0);
        push_eff = push_i & ~flush_i & ((count_q != 2'd2) | pop_eff);
        // write slot is head + count (mod 2); when full it equals the slot being popped
        wr_ptr   = rd_ptr_q ^ count_q[0];
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = 1'b0;
            count_d  = '0;
        end else begin
            if (pop_eff) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, push_eff} - {1'b0, pop_eff};
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage, written only on an accepted push
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_eff) begin
            mem_q[wr_ptr] <= push_data_i;
        end
    end

    // Head presentation
    always_comb begin
        count_o      = count_q;
        head_valid_o = (count_q != 2'd0);
        head_o       = mem_q[rd_ptr_q];
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads the combinational ROM, buffers
// {instr, pc} in a 2-entry skid queue towards decode, handles branch redirects
// and stops on the all-zero end-of-program word.
module fetch_unit #(
    parameter int unsigned                ADDR_W       = fetch_pkg::ADDR_W,
    parameter int unsigned                INSTR_W      = fetch_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0]          RESET_PC     = ADDR_W'(fetch_pkg::RESET_PC),
    parameter bit                         HALT_ON_ZERO = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               id_ready,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [ADDR_W-1:0]  if_pc_plus8,
    output logic               halted
);

    import fetch_pkg::*;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } entry_t;

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [1:0]        count;
    logic              head_valid;
    entry_t            head;
    entry_t            head_out;
    entry_t            push_data;
    logic              pop;
    logic              space;
    logic              fetch;
    logic              sentinel;
    logic              push;
    logic              run_en;

    // Fetch/redirect arbitration and PC next-state
    always_comb begin
        pop       = head_valid & id_ready;
        space     = (count < 2'd2) | pop;
        fetch     = run_en & space & ~redirect_valid;
        sentinel  = HALT_ON_ZERO && (imem_data == '0);
        push      = fetch & ~sentinel;
        push_data = '{instr: imem_data, pc: pc_q};
        pc_d      = pc_q;
        if (redirect_valid) begin
            pc_d = redirect_pc & ~ADDR_W'(3);
        end else if (push) begin
            pc_d = pc_q + ADDR_W'(PC_STEP);
        end
    end

    // PC register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: redirect always resumes, the zero sentinel stops fetch
    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            state_d = RUN;
        end else if (fetch && sentinel) begin
            state_d = HALT;
        end
    end

    // FSM outputs
    always_comb begin
        run_en = (state_q == RUN);
        halted = (state_q == HALT);
    end

    fetch_skid_fifo #(
        .entry_t (entry_t)
    ) u_fifo (
        .clk          (clk),
        .rst          (reset),
        .push_i       (push),
        .push_data_i  (push_data),
        .pop_i        (pop),
        .flush_i      (redirect_valid),
        .count_o      (count),
        .head_valid_o (head_valid),
        .head_o       (head)
    );

    // Decode-facing outputs; an empty queue presents zeros so if_pc_plus8 reads 8
    always_comb begin
        head_out    = head_valid ? head : '0;
        imem_addr   = pc_q;
        if_valid    = head_valid;
        if_instr    = head_out.instr;
        if_pc       = head_out.pc;
        if_pc_plus8 = head_out.pc + ADDR_W'(R15_OFFSET);
    end

endmodule
